// File: rtl/mem_resp_pkg.sv
// mem_resp_pkg: shared definitions for the memory responder and its users.
//   mstate_t  : responder state codes (MIDLE, MBUSY)
//   mop_t     : latched operation codes (OPRD, OPWR)
//   RWAIT_DEF / WWAIT_DEF : default wait-cycle counts, shared with the sequencer
package mem_resp_pkg;

    typedef enum logic {
        MIDLE = 1'b0,
        MBUSY = 1'b1
    } mstate_t;

    typedef enum logic {
        OPRD = 1'b0,
        OPWR = 1'b1
    } mop_t;

    localparam int unsigned RWAIT_DEF = 2;
    localparam int unsigned WWAIT_DEF = 1;

endpackage

// File: rtl/wait_cnt.sv
// wait_cnt: loadable down-counter used to time memory wait states.
//   clk, rst_n : clock, asynchronous active-low reset
//   ld, val    : load val into the counter (has priority over en)
//   en         : decrement by one
//   cnt        : current count
//   zero       : count is zero
module wait_cnt #(
    parameter int unsigned CW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ld,
    input  logic [CW-1:0] val,
    input  logic          en,
    output logic [CW-1:0] cnt,
    output logic          zero
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (ld) begin
            cnt <= val;
        end else if (en) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/mem_resp.sv
// mem_resp: memory-side responder for the CPU sequencer's rd/wr handshake.
// Accepts one-cycle strobes, holds kp high for RWAIT/WWAIT cycles, then
// commits the write or presents registered read data while dropping kp.
//   clk, rst_n : clock, asynchronous active-low reset
//   rd, wr     : one-cycle read / write request strobes
//   adr        : word address (sampled with the strobe)
//   din        : write data (sampled with wr)
//   dout       : registered read data, holds until the next read completes
//   kp         : access in progress, CPU must hold its state
//   err        : sticky protocol-error flag, cleared only by reset
module mem_resp
    import mem_resp_pkg::*;
#(
    parameter int unsigned AW    = 8,
    parameter int unsigned DW    = 16,
    parameter int unsigned RWAIT = RWAIT_DEF,
    parameter int unsigned WWAIT = WWAIT_DEF,
    parameter int unsigned CW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rd,
    input  logic          wr,
    input  logic [AW-1:0] adr,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          kp,
    output logic          err
);

    localparam logic [CW-1:0] RLOAD = (RWAIT > 0) ? CW'(RWAIT - 1) : '0;
    localparam logic [CW-1:0] WLOAD = (WWAIT > 0) ? CW'(WWAIT - 1) : '0;

    logic [DW-1:0] mem [0:(1 << AW) - 1];

    mstate_t       state, state_n;
    mop_t          op_q, op_n;
    logic [AW-1:0] adr_q;
    logic [DW-1:0] din_q;
    logic          kp_n, err_n;
    logic          lat_adr, lat_din;
    logic          cnt_ld, cnt_en, cnt_zero;
    logic [CW-1:0] cnt_val, cnt;
    logic          mem_we, rd_en;
    logic [AW-1:0] mem_wa, rd_a;
    logic [DW-1:0] mem_wd;

    // Decrement only while busy and not yet expired.
    assign cnt_en = (state == MBUSY) && (cnt != '0);

    wait_cnt #(.CW(CW)) u_wait_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .ld    (cnt_ld),
        .val   (cnt_val),
        .en    (cnt_en),
        .cnt   (cnt),
        .zero  (cnt_zero)
    );

    always_comb begin
        state_n = state;
        op_n    = op_q;
        kp_n    = kp;
        err_n   = err;
        lat_adr = 1'b0;
        lat_din = 1'b0;
        cnt_ld  = 1'b0;
        cnt_val = '0;
        mem_we  = 1'b0;
        mem_wa  = adr;
        mem_wd  = din;
        rd_en   = 1'b0;
        rd_a    = adr;
        case (state)
            MIDLE: begin
                if (rd && wr) begin
                    err_n = 1'b1;
                end else if (rd) begin
                    lat_adr = 1'b1;
                    op_n    = OPRD;
                    if (RWAIT == 0) begin
                        rd_en = 1'b1;
                    end else begin
                        kp_n    = 1'b1;
                        cnt_ld  = 1'b1;
                        cnt_val = RLOAD;
                        state_n = MBUSY;
                    end
                end else if (wr) begin
                    lat_adr = 1'b1;
                    lat_din = 1'b1;
                    op_n    = OPWR;
                    if (WWAIT == 0) begin
                        mem_we = 1'b1;
                    end else begin
                        kp_n    = 1'b1;
                        cnt_ld  = 1'b1;
                        cnt_val = WLOAD;
                        state_n = MBUSY;
                    end
                end
            end
            MBUSY: begin
                // Strobes while busy (including the completing edge) are errors
                // and never disturb the access in flight.
                if (rd || wr) begin
                    err_n = 1'b1;
                end
                if (cnt_zero) begin
                    if (op_q == OPRD) begin
                        rd_en = 1'b1;
                        rd_a  = adr_q;
                    end else begin
                        mem_we = 1'b1;
                        mem_wa = adr_q;
                        mem_wd = din_q;
                    end
                    kp_n    = 1'b0;
                    state_n = MIDLE;
                end
            end
            default: begin
                kp_n    = 1'b0;
                state_n = MIDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= MIDLE;
            op_q  <= OPRD;
            kp    <= 1'b0;
            err   <= 1'b0;
            dout  <= '0;
            adr_q <= '0;
            din_q <= '0;
        end else begin
            state <= state_n;
            op_q  <= op_n;
            kp    <= kp_n;
            err   <= err_n;
            if (lat_adr) adr_q <= adr;
            if (lat_din) din_q <= din;
            if (rd_en)   dout  <= mem[rd_a];
        end
    end

    // Array is not reset; gating with rst_n keeps a zero-wait write from
    // landing while reset is held.
    always_ff @(posedge clk) begin
        if (mem_we && rst_n) begin
            mem[mem_wa] <= mem_wd;
        end
    end

endmodule

// File: tb/tb_mem_resp.sv
module tb_mem_resp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;

    // Instance A: RWAIT=2, WWAIT=1
    logic        rst_a, rd_a, wr_a, kp_a, err_a;
    logic [7:0]  adr_a;
    logic [15:0] din_a, dout_a;
    // Instance Z: RWAIT=0, WWAIT=0
    logic        rst_z, rd_z, wr_z, kp_z, err_z;
    logic [7:0]  adr_z;
    logic [15:0] din_z, dout_z;
    // Instance S: RWAIT=3, WWAIT=2 (sequencer co-simulation)
    logic        rst_s, rd_s, wr_s, kp_s, err_s;
    logic [7:0]  adr_s;
    logic [15:0] din_s, dout_s;

    mem_resp #(.AW(8), .DW(16), .RWAIT(2), .WWAIT(1), .CW(4)) u_a (
        .clk(clk), .rst_n(rst_a), .rd(rd_a), .wr(wr_a), .adr(adr_a),
        .din(din_a), .dout(dout_a), .kp(kp_a), .err(err_a)
    );
    mem_resp #(.AW(8), .DW(16), .RWAIT(0), .WWAIT(0), .CW(4)) u_z (
        .clk(clk), .rst_n(rst_z), .rd(rd_z), .wr(wr_z), .adr(adr_z),
        .din(din_z), .dout(dout_z), .kp(kp_z), .err(err_z)
    );
    mem_resp #(.AW(8), .DW(16), .RWAIT(3), .WWAIT(2), .CW(4)) u_s (
        .clk(clk), .rst_n(rst_s), .rd(rd_s), .wr(wr_s), .adr(adr_s),
        .din(din_s), .dout(dout_s), .kp(kp_s), .err(err_s)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic [7:0]  adr;
        logic [15:0] din;
        logic        kp;
        logic [15:0] dout;
        logic        err;
    } vec_t;

    vec_t tbl [13];

    // Sequencer-style access on instance S: issue only with kp low, then
    // hold until kp drops, counting the held cycles.
    task automatic seq_access(input bit is_wr, input logic [7:0] a, input logic [15:0] d,
                              input int w, input logic [15:0] exp_rd);
        int held;
        chk("seq.kp_low_before_issue", 32'(kp_s), 32'd0);
        rd_s = !is_wr; wr_s = is_wr; adr_s = a; din_s = d;
        tick;
        rd_s = 1'b0; wr_s = 1'b0;
        held = 0;
        while (kp_s && held < 20) begin
            held++;
            tick;
        end
        chk(is_wr ? "seq.wr_hold" : "seq.rd_hold", 32'(held), 32'(w));
        if (!is_wr) chk("seq.rd_data", 32'(dout_s), 32'(exp_rd));
    endtask

    // Reference model state for randomized run on instance A
    logic [15:0] mm [256];
    bit          known [256];
    bit          pend;
    int          done_at;
    bit          m_wr;
    logic [7:0]  m_adr;
    logic [15:0] m_din;
    logic        m_err;
    logic [15:0] m_dout;
    bit          dout_known;

    task automatic model_complete;
        if (m_wr) begin
            mm[m_adr] = m_din;
            known[m_adr] = 1'b1;
        end else if (known[m_adr]) begin
            m_dout = mm[m_adr];
            dout_known = 1'b1;
        end else begin
            dout_known = 1'b0;
        end
    endtask

    initial begin
        rst_a = 0; rd_a = 0; wr_a = 0; adr_a = '0; din_a = '0;
        rst_z = 0; rd_z = 0; wr_z = 0; adr_z = '0; din_z = '0;
        rst_s = 0; rd_s = 0; wr_s = 0; adr_s = '0; din_s = '0;
        tick; tick;
        chk("reset.kp",   32'(kp_a),   32'd0);
        chk("reset.dout", 32'(dout_a), 32'd0);
        chk("reset.err",  32'(err_a),  32'd0);
        chk("reset_z.kp", 32'(kp_z),   32'd0);
        rst_a = 1; rst_z = 1; rst_s = 1;

        // rows: rd, wr, adr, din -> kp, dout, err after the edge
        tbl[0]  = '{1'b0, 1'b1, 8'h10, 16'hBEEF, 1'b1, 16'h0000, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 16'h0000, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 8'h10, 16'h0000, 1'b1, 16'h0000, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 16'h0000, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 16'hBEEF, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 8'h05, 16'h1234, 1'b1, 16'hBEEF, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 16'hBEEF, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 8'h05, 16'h0000, 1'b1, 16'hBEEF, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 16'hBEEF, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 16'h1234, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 8'h10, 16'h0000, 1'b1, 16'h1234, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 8'h05, 16'h0000, 1'b1, 16'h1234, 1'b1};
        tbl[12] = '{1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 16'hBEEF, 1'b1};

        for (int i = 0; i < 13; i++) begin
            rd_a = tbl[i].rd; wr_a = tbl[i].wr; adr_a = tbl[i].adr; din_a = tbl[i].din;
            tick;
            rd_a = 1'b0; wr_a = 1'b0;
            chk($sformatf("vec%0d.kp", i),   32'(kp_a),   32'(tbl[i].kp));
            chk($sformatf("vec%0d.dout", i), 32'(dout_a), 32'(tbl[i].dout));
            chk($sformatf("vec%0d.err", i),  32'(err_a),  32'(tbl[i].err));
        end

        // rd and wr together in a fresh run
        rst_a = 0; tick; rst_a = 1;
        chk("both.err_cleared", 32'(err_a), 32'd0);
        rd_a = 1; wr_a = 1; adr_a = 8'h05; din_a = 16'hFFFF;
        tick;
        rd_a = 0; wr_a = 0;
        chk("both.err", 32'(err_a), 32'd1);
        chk("both.kp",  32'(kp_a),  32'd0);
        rd_a = 1; adr_a = 8'h05;
        tick;
        rd_a = 0;
        tick; tick;
        chk("both.mem_unchanged", 32'(dout_a), 32'h1234);

        // Reset mid-write discards the pending write
        rst_a = 0; tick; rst_a = 1;
        wr_a = 1; adr_a = 8'h20; din_a = 16'h5555;
        tick; wr_a = 0; tick;
        rd_a = 1; adr_a = 8'h20;
        tick; rd_a = 0; tick; tick;
        chk("rstmid.pre_read", 32'(dout_a), 32'h5555);
        wr_a = 1; adr_a = 8'h20; din_a = 16'hAAAA;
        tick; wr_a = 0;
        chk("rstmid.kp_busy", 32'(kp_a), 32'd1);
        rst_a = 0;
        #1;
        chk("rstmid.kp_async",   32'(kp_a),   32'd0);
        chk("rstmid.dout_async", 32'(dout_a), 32'd0);
        tick; tick;
        rst_a = 1;
        rd_a = 1; adr_a = 8'h20;
        tick; rd_a = 0; tick; tick;
        chk("rstmid.old_value", 32'(dout_a), 32'h5555);
        chk("rstmid.kp_done",   32'(kp_a),   32'd0);

        // Zero-wait build
        wr_z = 1; adr_z = 8'hFF; din_z = 16'h7777;
        tick; wr_z = 0;
        chk("zw.wr_kp", 32'(kp_z), 32'd0);
        rd_z = 1; adr_z = 8'hFF;
        tick; rd_z = 0;
        chk("zw.rd_kp",   32'(kp_z),   32'd0);
        chk("zw.rd_dout", 32'(dout_z), 32'h7777);
        chk("zw.err",     32'(err_z),  32'd0);

        // Sequencer co-simulation: store a small program, then fetch it
        for (int i = 0; i < 4; i++)
            seq_access(1'b1, 8'(i * 7), 16'(i * 16'h1111 + 3), 2, 16'h0);
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < 4; i++)
                seq_access(1'b0, 8'(i * 7), 16'h0, 3, 16'(i * 16'h1111 + 3));
        chk("seq.err", 32'(err_s), 32'd0);

        // Randomized run on instance A against the reference model
        rst_a = 0; tick; rst_a = 1;
        foreach (known[k]) known[k] = 1'b0;
        pend = 0; done_at = 0; m_err = 0; m_dout = '0; dout_known = 1; m_wr = 0;
        m_adr = '0; m_din = '0;
        for (int t = 0; t < 400; t++) begin
            int r;
            logic srd, swr;
            logic [7:0] sa;
            logic [15:0] sd;
            r = $urandom_range(0, 99);
            srd = (r < 20) || (r >= 40 && r < 43);
            swr = (r >= 20 && r < 43);
            sa = 8'($urandom_range(0, 15));
            sd = 16'($urandom);
            rd_a = srd; wr_a = swr; adr_a = sa; din_a = sd;
            tick;
            rd_a = 0; wr_a = 0;
            if (pend) begin
                if (srd || swr) m_err = 1'b1;
                if (t == done_at) begin
                    model_complete;
                    pend = 0;
                end
            end else if (srd && swr) begin
                m_err = 1'b1;
            end else if (srd || swr) begin
                int w;
                w = srd ? 2 : 1;
                m_wr = swr; m_adr = sa; m_din = sd;
                if (w == 0) model_complete;
                else begin
                    pend = 1;
                    done_at = t + w;
                end
            end
            chk($sformatf("rnd%0d.kp", t),  32'(kp_a),  32'(pend));
            chk($sformatf("rnd%0d.err", t), 32'(err_a), 32'(m_err));
            if (dout_known) chk($sformatf("rnd%0d.dout", t), 32'(dout_a), 32'(m_dout));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/mem_resp.md
Name: mem_resp

Overview:
Memory-side responder for the CPU sequencer's read/write handshake. It accepts one-cycle rd/wr strobes, holds kp high for a parameterised number of wait cycles, then commits the write or presents read data while dropping kp. The CPU advances out of its read states only once kp is low. The block sits between the sequencer/datapath and a synchronous word-addressed RAM array held internally.

Parameters:
AW, 8, address width (memory depth 2**AW words)
DW, 16, data word width
RWAIT, 2, read wait cycles (kp-high cycles per read), legal 0..15
WWAIT, 1, write wait cycles, legal 0..15
CW, 4, wait counter width; must satisfy 2**CW > max(RWAIT,WWAIT)

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
rd  in  1  read request strobe, sampled on posedge, one cycle wide
wr  in  1  write request strobe, sampled on posedge, one cycle wide
adr  in  AW  word address, sampled with the strobe
din  in  DW  write data, sampled with wr
dout  out  DW  read data, registered
kp  out  1  keep/wait: high = access in progress, CPU must hold state
err  out  1  sticky protocol-error flag

Behaviour:
- Reset (rst_n low, asynchronous): state MIDLE, kp=0, dout=0, err=0, counter=0, latched adr/din/op cleared. Memory contents are not reset. Reset mid-access aborts the access; a pending write is discarded.
- States: MIDLE, MBUSY (shared encoding).
- MIDLE, rd=1, wr=0 at an edge: latch adr and op=read.
  - If RWAIT>0: kp<=1, cnt<=RWAIT-1, go MBUSY.
  - If RWAIT=0: dout<=mem[adr] on the same edge, kp stays 0.
- MIDLE, wr=1, rd=0: latch adr, din, op=write. Same as read with WWAIT. For WWAIT=0, mem[adr]<=din on that edge.
- MBUSY, cnt!=0: cnt<=cnt-1, kp stays 1.
- MBUSY, cnt==0:
  - Read: dout<=mem[adr_q]. Write: mem[adr_q]<=din_q.
  - kp<=0, go MIDLE.
- Timing: kp is high for exactly RWAIT (or WWAIT) cycles, starting the cycle after the strobe edge. dout is valid in the first kp-low cycle and holds until the next read completes. Writes never change dout.
- rd and wr high together in MIDLE: no access, err<=1, kp stays 0.
- Any rd or wr while in MBUSY: strobe ignored, err<=1, current access continues unaffected.
- A strobe on the same edge the access completes (MBUSY, cnt==0) is also an error. The CPU must re-issue only after seeing kp low.
- err clears only on reset.
- Back-to-back accesses: a new strobe is accepted in the first MIDLE cycle after completion. Minimum issue interval is WAIT+1 cycles.
- Address wrap: adr is used modulo 2**AW, with no bounds check.
- Unknown/default state: recover to MIDLE with kp=0.

Decomposition:
- Shared header `../data/mem_d.v` holds:
  - state codes `MIDLE` and `MBUSY`
  - op codes `OPRD` and `OPWR`
  - defaults for RWAIT and WWAIT, so the sequencer and the bench agree.
- One natural sub-module, wait_cnt: loadable down-counter (ld, val, en → cnt, zero), instantiated once.
- The memory array remains inline.

Test Plan:
- Reset then single read, RWAIT=2, mem[0x10] preloaded to 0xBEEF: rd pulse at cycle 0 → kp=1 in cycles 1-2, kp=0 and dout=0xBEEF in cycle 3; err=0.
- Write then read-back, WWAIT=1: wr adr=0x05 din=0x1234 → kp=1 for 1 cycle. Then rd adr=0x05 → dout=0x1234 after 2 kp cycles. dout is unchanged by the write.
- RWAIT=0 and WWAIT=0 build: rd adr=0xFF → dout valid next cycle, kp never rises. Write to 0xFF followed by a read returns the written value.
- Protocol errors: rd while kp=1 → err=1 and the first read still returns the correct data. In a fresh run, rd and wr in the same cycle → err=1, no memory change, kp=0.
- Reset mid-access: wr adr=0x20 din=0xAAAA, assert rst_n low while kp=1 → kp=0, dout=0 immediately. After release, rd 0x20 returns the old value, not 0xAAAA.
- Sequencer co-simulation: run a program fetch/execute loop with RWAIT=3. The CPU holds its read states for exactly 3 cycles per access and never issues while kp=1 (err stays 0).
